otter_fetch_unit: RTL and testbench

Instruction fetch stage for the multicycle OTTER RISC-V core. It sits directly upstream of the immediate generator and decoder. It holds the program counter, issues one word request at a time to instruction memory, and captures the returned word into the instruction register. It then presents that register (`ir`) downstream until the control unit acknowledges it and supplies the next-PC selection.

---
 rtl/otter_fetch_unit.sv | 114 +++++++++++
 tb/tb_otter_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/otter_fetch_unit.sv
// OTTER multicycle fetch stage: PC, one-at-a-time imem request, IR capture.
// Holds IR until the control unit acknowledges and picks the next PC.
module otter_fetch_unit #(
   parameter int n = 32,
   parameter logic [n-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic         mem_req,
   output logic [n-1:0] mem_addr,
   input  logic [n-1:0] mem_rdata,
   input  logic         mem_valid,
   output logic [n-1:0] ir,
   output logic         ir_valid,
   input  logic         ir_ack,
   input  logic [2:0]   pc_source,
   input  logic [n-1:0] jalr,
   input  logic [n-1:0] branch,
   input  logic [n-1:0] jal,
   input  logic [n-1:0] mtvec,
   input  logic [n-1:0] mepc,
   output logic [n-1:0] pc,
   output logic [n-1:0] pc_plus4,
   output logic         misaligned
);

   localparam logic [n-1:0] NOP = n'(32'h0000_0013);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [n-1:0] target;
   logic         ld_ir;
   logic         ld_pc;
   logic         trap;

   assign pc_plus4 = pc + n'(4);
   assign mem_addr = pc;
   assign mem_req  = (state == FETCH);

   always_comb begin
      target = pc_plus4;
      case (pc_source)
         3'd1:    target = jalr;
         3'd2:    target = branch;
         3'd3:    target = jal;
         3'd4:    target = mtvec;
         3'd5:    target = mepc;
         default: target = pc_plus4;
      endcase
   end

   always_comb begin
      state_nxt = state;
      ld_ir     = 1'b0;
      ld_pc     = 1'b0;
      trap      = 1'b0;
      case (state)
         FETCH: begin
            if (mem_valid) begin
               ld_ir     = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (ir_ack) begin
               // a misaligned target freezes fetch until reset
               if (target[1:0] == 2'b00) begin
                  ld_pc     = 1'b1;
                  state_nxt = FETCH;
               end else begin
                  trap      = 1'b1;
                  state_nxt = HALT;
               end
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         ir         <= NOP;
         ir_valid   <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         if (ld_ir) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
         end
         if (ld_pc) begin
            pc       <= target;
            ir_valid <= 1'b0;
         end
         if (trap) begin
            misaligned <= 1'b1;
            ir_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Randomized + directed bench for otter_fetch_unit against a behavioural model.
// Model is checked every cycle; directed steps pin literal expectations.
module tb_otter_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ir_ack;
   logic [2:0]  pc_source;
   logic [31:0] jalr, branch, jal, mtvec, mepc;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misaligned;

   int tests = 0;
   int fails = 0;

   otter_fetch_unit #(.n(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .ir(ir), .ir_valid(ir_valid), .ir_ack(ir_ack),
      .pc_source(pc_source),
      .jalr(jalr), .branch(branch), .jal(jal),
      .mtvec(mtvec), .mepc(mepc),
      .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model: instruction in hand, halted flag, current pc
   bit          m_ok = 0;
   logic [31:0] m_pc, m_ir;
   bit          m_have, m_halt;

   function automatic logic [31:0] pick(input logic [2:0] s,
                                        input logic [31:0] cur);
      logic [31:0] t[8];
      t[0] = cur + 4; t[1] = jalr; t[2] = branch; t[3] = jal;
      t[4] = mtvec;   t[5] = mepc; t[6] = cur + 4; t[7] = cur + 4;
      return t[s];
   endfunction

   always @(posedge clk) begin
      logic [31:0] nxt;
      if (!rst_n) begin
         m_ok = 1; m_pc = 32'h0; m_ir = 32'h13;
         m_have = 0; m_halt = 0;
      end else if (m_ok) begin
         if (!m_have && !m_halt) begin
            if (mem_valid) begin
               m_ir = mem_rdata;
               m_have = 1;
            end
         end else if (m_have && ir_ack) begin
            nxt = pick(pc_source, m_pc);
            m_have = 0;
            if (nxt % 4 == 0) m_pc = nxt;
            else m_halt = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m.mem_req", {31'b0, mem_req}, {31'b0, !m_have && !m_halt});
         chk("m.mem_addr", mem_addr, m_pc);
         chk("m.pc", pc, m_pc);
         chk("m.pc_plus4", pc_plus4, m_pc + 32'd4);
         chk("m.ir", ir, m_ir);
         chk("m.ir_valid", {31'b0, ir_valid}, {31'b0, m_have});
         chk("m.misaligned", {31'b0, misaligned}, {31'b0, m_halt});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic fetch(input logic [31:0] w);
      mem_valid = 1; mem_rdata = w;
      tick();
      mem_valid = 0;
   endtask

   task automatic ack(input logic [2:0] s);
      ir_ack = 1; pc_source = s;
      tick();
      ir_ack = 0;
   endtask

   initial begin
      rst_n = 0; mem_valid = 0; mem_rdata = 0; ir_ack = 0;
      pc_source = 0; jalr = 0; branch = 0; jal = 0; mtvec = 0; mepc = 0;

      // reset
      tick(); tick();
      rst_n = 1;
      chk("rst.mem_req", {31'b0, mem_req}, 32'd1);
      chk("rst.mem_addr", mem_addr, 32'h0);
      chk("rst.ir", ir, 32'h13);
      chk("rst.ir_valid", {31'b0, ir_valid}, 32'd0);
      chk("rst.misaligned", {31'b0, misaligned}, 32'd0);

      // sequential fetch, memory answers after one cycle
      tick();
      fetch(32'h0050_0093);
      chk("seq.ir", ir, 32'h0050_0093);
      chk("seq.ir_valid", {31'b0, ir_valid}, 32'd1);
      chk("seq.mem_req", {31'b0, mem_req}, 32'd0);
      ack(3'd0);
      chk("seq.mem_addr", mem_addr, 32'h4);
      chk("seq.pc_plus4", pc_plus4, 32'h8);
      chk("seq.req", {31'b0, mem_req}, 32'd1);

      // walk to 0x10 then branch
      for (int i = 0; i < 3; i++) begin
         fetch(32'h13);
         ack(3'd6);
      end
      fetch(32'h0000_0063);
      chk("br.pc", pc, 32'h10);
      branch = 32'h40;
      ack(3'd2);
      chk("br.mem_addr", mem_addr, 32'h40);
      chk("br.ir_valid", {31'b0, ir_valid}, 32'd0);

      // stall with spurious mem_valid
      fetch(32'hDEAD_BEEF & ~32'h0);
      for (int i = 0; i < 5; i++) begin
         mem_valid = i[0]; mem_rdata = $urandom;
         tick();
         chk("stall.ir", ir, 32'hDEAD_BEEF);
         chk("stall.pc", pc, 32'h40);
         chk("stall.mem_req", {31'b0, mem_req}, 32'd0);
      end
      mem_valid = 0;

      // misaligned jalr
      jalr = 32'h102;
      ack(3'd1);
      chk("mis.flag", {31'b0, misaligned}, 32'd1);
      chk("mis.pc", pc, 32'h40);
      chk("mis.mem_req", {31'b0, mem_req}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1;
         ack(3'd0);
         chk("halt.pc", pc, 32'h40);
         chk("halt.mem_req", {31'b0, mem_req}, 32'd0);
      end
      mem_valid = 0;

      // reset, then reset again mid-fetch with a coincident mem_valid
      rst_n = 0; tick(); rst_n = 1;
      chk("rmf.req", {31'b0, mem_req}, 32'd1);
      tick();
      rst_n = 0; mem_valid = 1; mem_rdata = 32'h1234_5678;
      tick();
      rst_n = 1; mem_valid = 0;
      chk("rmf.mem_addr", mem_addr, 32'h0);
      chk("rmf.ir", ir, 32'h13);
      chk("rmf.ir_valid", {31'b0, ir_valid}, 32'd0);

      // wrap from top of address space
      fetch(32'h13);
      jal = 32'hFFFF_FFFC;
      ack(3'd3);
      chk("wrap.top", mem_addr, 32'hFFFF_FFFC);
      fetch(32'h13);
      chk("wrap.pc_plus4", pc_plus4, 32'h0);
      ack(3'd0);
      chk("wrap.mem_addr", mem_addr, 32'h0);

      // random phase
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(63) != 0);
         mem_valid = $urandom_range(1);
         mem_rdata = $urandom;
         ir_ack    = $urandom_range(1);
         pc_source = 3'($urandom_range(7));
         jalr      = $urandom & ~32'h3;
         branch    = $urandom & ~32'h3;
         jal       = $urandom & ~32'h3;
         mtvec     = $urandom & ~32'h3;
         mepc      = $urandom & ~32'h3;
         if ($urandom_range(15) == 0) jalr[1:0] = 2'($urandom_range(3));
         if ($urandom_range(31) == 0) mepc[0] = 1'b1;
         tick();
      end
      rst_n = 1; mem_valid = 0; ir_ack = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
